apb_slv_memory: RTL and testbench



---
 rtl/apb_slv_pkg.sv | 18 +
 rtl/apb_slv_mem_array.sv | 52 +++++
 rtl/apb_slv_memory.sv | 120 ++++++++++++
 tb/tb_apb_slv_memory.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB completer memory.
// FSM encodings, default bus widths and the strobe-width helper.
package apb_slv_pkg;

  localparam int unsigned DEF_DATA_SIZE = 32;
  localparam int unsigned DEF_ADDR_SIZE = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    W_ENABLE = 2'b01,
    R_ENABLE = 2'b10
  } apb_state_e;

  function automatic int unsigned strb_width(input int unsigned data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/apb_slv_mem_array.sv
// Word-addressed register-file memory: synchronous clear, byte-enable write port and
// registered read port. Out-of-range writes are dropped and out-of-range reads return 0.
module apb_slv_mem_array
  import apb_slv_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                we,
  input  logic [ADDR_SIZE-1:0]                waddr,
  input  logic [DATA_SIZE-1:0]                wdata,
  input  logic [strb_width(DATA_SIZE)-1:0]    wstrb,
  input  logic                                re,
  input  logic [ADDR_SIZE-1:0]                raddr,
  output logic [DATA_SIZE-1:0]                rdata
);

  localparam int unsigned STRB_SIZE = strb_width(DATA_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
  logic                 wr_ok;
  logic                 rd_ok;

  assign wr_ok = ({1'b0, waddr} < DEPTH);
  assign rd_ok = ({1'b0, raddr} < DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we && wr_ok) begin
        for (int unsigned l = 0; l < STRB_SIZE; l++) begin
          if (wstrb[l]) begin
            mem[waddr][8*l +: 8] <= wdata[8*l +: 8];
          end
        end
      end
      // Read data only moves on a read setup; it holds across the access and after.
      if (re) begin
        rdata <= rd_ok ? mem[raddr] : '0;
      end
    end
  end

endmodule

// File: rtl/apb_slv_memory.sv
// Zero-wait-state APB completer around apb_slv_mem_array.
// Request fields are captured at setup; the memory write happens on the completing edge.
module apb_slv_memory
  import apb_slv_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned MEM_DEPTH = 2 ** ADDR_SIZE
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [ADDR_SIZE-1:0]             PADDR,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [DATA_SIZE-1:0]             PWDATA,
  input  logic [strb_width(DATA_SIZE)-1:0] PSTROBE,
  output logic                             PREADY,
  output logic [DATA_SIZE-1:0]             PRDATA,
  output logic                             PSLVERR
);

  localparam int unsigned STRB_SIZE = strb_width(DATA_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);

  apb_state_e           state_q, state_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic [STRB_SIZE-1:0] strb_q;
  logic                 latch;
  logic                 mem_we;
  logic                 mem_re;
  logic                 setup;
  logic                 addr_ok;

  assign setup   = PSEL && !PENABLE;
  assign addr_ok = ({1'b0, PADDR} < DEPTH);

  always_comb begin
    state_d   = state_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    latch     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        // PSEL with PENABLE already high here is a protocol violation and is ignored.
        if (setup) begin
          latch     = 1'b1;
          state_d   = PWRITE ? W_ENABLE : R_ENABLE;
          pready_d  = 1'b1;
          pslverr_d = !addr_ok;
          mem_re    = !PWRITE;
        end
      end
      W_ENABLE, R_ENABLE: begin
        if (!PSEL) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (PENABLE) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          mem_we    = (state_q == W_ENABLE);
        end
      end
      default: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (latch) begin
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
        strb_q  <= PSTROBE;
      end
    end
  end

  apb_slv_mem_array #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .re    (mem_re),
    .raddr (PADDR),
    .rdata (PRDATA)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slv_memory.sv
// Self-checking bench: a full-depth and a 48-word instance share one APB bus and are
// compared every cycle against a transaction-level memory model.
module tb_apb_slv_memory;

  logic        PCLK;
  logic        PRESETn;
  logic [5:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTROBE;

  logic        rdy0, rdy1, err0, err1;
  logic [31:0] rd0, rd1;

  apb_slv_memory u_dut (
    .PCLK (PCLK), .PRESETn (PRESETn), .PADDR (PADDR), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PWDATA (PWDATA), .PSTROBE (PSTROBE),
    .PREADY (rdy0), .PRDATA (rd0), .PSLVERR (err0)
  );

  apb_slv_memory #(.MEM_DEPTH (48)) u_dut48 (
    .PCLK (PCLK), .PRESETn (PRESETn), .PADDR (PADDR), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PWDATA (PWDATA), .PSTROBE (PSTROBE),
    .PREADY (rdy1), .PRDATA (rd1), .PSLVERR (err1)
  );

  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 0;
  int unsigned dep [2];
  logic [31:0] mdl [2][64];
  logic        exp_rdy;
  logic        exp_errchk;
  logic        exp_err [2];
  logic [31:0] exp_rd [2];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      check("pready64", {31'b0, rdy0}, {31'b0, exp_rdy});
      check("pready48", {31'b0, rdy1}, {31'b0, exp_rdy});
      check("prdata64", rd0, exp_rd[0]);
      check("prdata48", rd1, exp_rd[1]);
      if (exp_errchk) begin
        check("pslverr64", {31'b0, err0}, {31'b0, exp_err[0]});
        check("pslverr48", {31'b0, err1}, {31'b0, exp_err[1]});
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (s[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mdl[k][i] = '0;
      exp_err[k] = 1'b0;
      exp_rd[k]  = '0;
    end
    exp_rdy    = 1'b0;
    exp_errchk = 1'b1;
  endtask

  // One transfer; got0/got1/gerr1 are sampled mid-way through the first access cycle.
  task automatic xfer(input bit wr, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int stretch, input bit abort,
                      input bit scr, input bit rmid,
                      output logic [31:0] got0, output logic [31:0] got1,
                      output logic gerr1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTROBE = s;
    @(posedge PCLK); #1;
    exp_rdy    = 1'b1;
    exp_errchk = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_err[k] = (32'(a) >= dep[k]);
      if (!wr) exp_rd[k] = (32'(a) < dep[k]) ? mdl[k][a] : 32'h0;
    end
    @(negedge PCLK);
    got0 = rd0; got1 = rd1; gerr1 = err1;
    repeat (stretch) begin @(posedge PCLK); #1; end
    if (abort) PSEL = 1'b0;
    else PENABLE = 1'b1;
    if (scr) begin
      PADDR = 6'($urandom); PWDATA = $urandom; PSTROBE = 4'($urandom);
      PWRITE = 1'($urandom);
    end
    if (rmid) PRESETn = 1'b0;
    @(posedge PCLK); #1;
    if (rmid) begin
      clear_model();
      PRESETn = 1'b1;
    end else if (abort) begin
      exp_rdy    = 1'b0;
      exp_errchk = 1'b0;
    end else begin
      if (wr) begin
        for (int k = 0; k < 2; k++)
          if (32'(a) < dep[k]) mdl[k][a] = merge(mdl[k][a], d, s);
      end
      exp_rdy    = 1'b0;
      exp_err[0] = 1'b0;
      exp_err[1] = 1'b0;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle_cycle(input bit violate);
    PSEL = violate; PENABLE = violate;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  logic [31:0] g0, g1;
  logic        ge;
  logic [3:0]  strb_tab [5];
  logic [31:0] lit_tab  [5];

  initial begin
    dep[0] = 64; dep[1] = 48;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTROBE = '0;
    strb_tab = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    lit_tab  = '{32'h00550000, 32'h00005555, 32'h00005500, 32'h00000055, 32'h00000000};

    @(posedge PCLK); #1;
    clear_model();
    chk_en = 1;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    idle_cycle(0);

    // Everything reads zero after reset; the 48-word instance flags 48..63.
    for (int i = 0; i < 64; i++) xfer(0, 6'(i), '0, '0, 0, 0, 0, 0, g0, g1, ge);

    xfer(1, 6'd5, 32'h55555555, 4'hF, 0, 0, 0, 0, g0, g1, ge);
    xfer(0, 6'd5, '0, '0, 0, 0, 0, 0, g0, g1, ge);
    check("lit_rd5", g0, 32'h55555555);

    for (int i = 0; i < 5; i++)
      xfer(1, 6'(i), 32'h55555555, strb_tab[i], 0, 0, 0, 0, g0, g1, ge);
    for (int i = 0; i < 5; i++) begin
      xfer(0, 6'(i), '0, '0, 0, 0, 0, 0, g0, g1, ge);
      check("lit_strobe", g0, lit_tab[i]);
    end

    for (int i = 0; i < 50; i++) begin
      xfer(1, 6'(i), 32'h55555555, 4'(4 - i), 0, 0, 0, 0, g0, g1, ge);
      idle_cycle(0);
    end
    check("lit_mdl10", mdl[0][10], 32'h55005500);
    for (int i = 0; i < 64; i++) begin
      xfer(0, 6'(i), '0, '0, 0, 0, 0, 0, g0, g1, ge);
      if (i == 10) check("lit_rd10", g0, 32'h55005500);
      if (i == 47) check("lit48_rd47", g1, 32'h00550055);
      if (i == 49) begin
        check("lit_rd49", g0, 32'h00005555);
        check("lit48_rd49", g1, 32'h0);
        check("lit48_err49", {31'b0, ge}, 32'h1);
      end
      if (i == 55) check("lit_rd55", g0, 32'h0);
    end

    xfer(1, 6'd7, 32'hAAAAAAAA, 4'hF, 0, 1, 0, 0, g0, g1, ge);
    xfer(0, 6'd7, '0, '0, 0, 0, 0, 0, g0, g1, ge);
    check("lit_abort7", g0, 32'h55550055);

    xfer(1, 6'd50, 32'h12345678, 4'hF, 0, 0, 0, 0, g0, g1, ge);
    xfer(0, 6'd50, '0, '0, 1, 0, 1, 0, g0, g1, ge);
    check("lit_rd50", g0, 32'h12345678);
    check("lit48_rd50", g1, 32'h0);
    check("lit48_err50", {31'b0, ge}, 32'h1);

    idle_cycle(1);
    xfer(0, 6'd1, '0, '0, 0, 0, 0, 0, g0, g1, ge);
    check("lit_after_violation", g0, 32'h00005555);

    for (int n = 0; n < 400; n++) begin
      xfer(1'($urandom), 6'($urandom), $urandom, 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0),
           1, 0, g0, g1, ge);
      case ($urandom_range(0, 3))
        0: idle_cycle(0);
        1: idle_cycle(1);
        default: ;
      endcase
    end

    xfer(1, 6'd5, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 1, g0, g1, ge);
    for (int i = 0; i < 64; i++) begin
      xfer(0, 6'(i), '0, '0, 0, 0, 0, 0, g0, g1, ge);
      if (i == 5) check("lit_rst_rd5", g0, 32'h0);
    end

    idle_cycle(0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
